// File: rtl/mul_share_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter: pipeline tag and arbitration modes.
package mul_share_arb_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Tag fields are sized for the largest legal configuration (8 requesters, 4 lanes).
    localparam int unsigned TAG_ID_W   = 3;
    localparam int unsigned TAG_LANE_W = 4;

    typedef struct packed {
        logic                  vld;
        logic [TAG_ID_W-1:0]   id;
        logic [TAG_LANE_W-1:0] lane_en;
    } tag_t;

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester-side bus of the shared multiplier bank: requests in, grant and results out.
interface mul_share_arb_if #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned LANES = 2,
    parameter int unsigned W     = 32
);
    logic [NREQ-1:0]           req_vld;
    logic [NREQ-1:0]           req_lock;
    logic [NREQ*LANES-1:0]     req_lane_en;
    logic [NREQ*LANES*W-1:0]   req_a;
    logic [NREQ*LANES*W-1:0]   req_b;
    logic [NREQ-1:0]           gnt;
    logic [NREQ-1:0]           rsp_vld;
    logic [LANES*2*W-1:0]      rsp_out;
    logic                      busy;

    modport master (
        output req_vld, req_lock, req_lane_en, req_a, req_b,
        input  gnt, rsp_vld, rsp_out, busy
    );

    modport slave (
        input  req_vld, req_lock, req_lane_en, req_a, req_b,
        output gnt, rsp_vld, rsp_out, busy
    );
endinterface

// File: rtl/mul_share_arb_mul_pipe.sv
// One multiplier lane: zero-gated operands, W x W -> 2W product delayed by LAT registers.
module mul_pipe #(
    parameter int unsigned W   = 32,
    parameter int unsigned LAT = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    localparam int unsigned PW = 2 * W;

    logic [W-1:0]  a_g;
    logic [W-1:0]  b_g;
    logic [PW-1:0] stage_q [LAT];

    always_comb begin
        a_g = en ? a : '0;
        b_g = en ? b : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < LAT; s++) stage_q[s] <= '0;
        end else begin
            stage_q[0] <= PW'(a_g) * PW'(b_g);
            for (int unsigned s = 1; s < LAT; s++) stage_q[s] <= stage_q[s-1];
        end
    end

    assign p = stage_q[LAT-1];

endmodule

// File: rtl/mul_share_arb.sv
// Arbitrates NREQ requesters onto LANES shared pipelined multipliers, with lock,
// fixed-priority or round-robin selection, and per-requester result tagging.
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned LANES = 2,
    parameter int unsigned W     = 32,
    parameter int unsigned LAT   = 2,
    parameter int unsigned RR    = ARB_FIXED
) (
    input logic             clk,
    input logic             reset,
    mul_share_arb_if.slave  bus
);
    localparam int unsigned PW = 2 * W;

    logic                  lock_vld;
    logic [TAG_ID_W-1:0]   lock_own;
    logic [TAG_ID_W-1:0]   rr_ptr;
    logic [TAG_ID_W-1:0]   rr_next;
    logic                  gnt_any;
    logic [TAG_ID_W-1:0]   gnt_idx;
    logic [NREQ-1:0]       gnt;
    logic [2*NREQ-1:0]     rr_view;
    logic [TAG_ID_W:0]     rr_sum;
    logic                  lock_req;
    logic [LANES-1:0]      lane_en_sel;
    logic [W-1:0]          a_sel [LANES];
    logic [W-1:0]          b_sel [LANES];
    logic [PW-1:0]         prod  [LANES];
    tag_t                  tag_in;
    tag_t                  tag_q [LAT];
    tag_t                  tag_out;
    logic                  unused_tag;

    // Arbitration: a live lock wins, otherwise fixed priority or rotated search.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        rr_view = {bus.req_vld, bus.req_vld} >> rr_ptr;
        if (!reset) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (lock_vld && lock_own == TAG_ID_W'(i) && bus.req_vld[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = TAG_ID_W'(i);
                end
            end
            if (!gnt_any) begin
                if (RR == ARB_RR) begin
                    for (int unsigned k = 0; k < NREQ; k++) begin
                        if (!gnt_any && rr_view[k]) begin
                            gnt_any = 1'b1;
                            rr_sum  = {1'b0, rr_ptr} + (TAG_ID_W+1)'(k);
                            if (rr_sum >= (TAG_ID_W+1)'(NREQ)) rr_sum = rr_sum - (TAG_ID_W+1)'(NREQ);
                            gnt_idx = rr_sum[TAG_ID_W-1:0];
                        end
                    end
                end else begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (!gnt_any && bus.req_vld[i]) begin
                            gnt_any = 1'b1;
                            gnt_idx = TAG_ID_W'(i);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) gnt[i] = gnt_any && (gnt_idx == TAG_ID_W'(i));
    end

    assign bus.gnt = gnt;
    assign rr_next = (gnt_idx == TAG_ID_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_ID_W'(1);

    always_comb begin
        lock_req    = 1'b0;
        lane_en_sel = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            a_sel[l] = '0;
            b_sel[l] = '0;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                lock_req    = bus.req_lock[i];
                lane_en_sel = bus.req_lane_en[i*LANES +: LANES];
                for (int unsigned l = 0; l < LANES; l++) begin
                    a_sel[l] = bus.req_a[(i*LANES+l)*W +: W];
                    b_sel[l] = bus.req_b[(i*LANES+l)*W +: W];
                end
            end
        end
    end

    // Any cycle without an issue drops the lock; the pointer only moves on unlocked issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld <= 1'b0;
            lock_own <= '0;
            rr_ptr   <= '0;
        end else begin
            lock_vld <= gnt_any && lock_req;
            if (gnt_any) begin
                lock_own <= gnt_idx;
                if (!lock_req) rr_ptr <= rr_next;
            end
        end
    end

    always_comb begin
        tag_in                     = '0;
        tag_in.vld                 = gnt_any;
        tag_in.id                  = gnt_idx;
        tag_in.lane_en[LANES-1:0]  = lane_en_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mul_pipe #(
            .W   (W),
            .LAT (LAT)
        ) u_mul (
            .clk   (clk),
            .reset (reset),
            .en    (gnt_any && lane_en_sel[l]),
            .a     (a_sel[l]),
            .b     (b_sel[l]),
            .p     (prod[l])
        );
    end

    assign tag_out    = tag_q[LAT-1];
    assign unused_tag = ^tag_out;

    always_comb begin
        bus.rsp_vld = '0;
        bus.rsp_out = '0;
        bus.busy    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++)
            bus.rsp_vld[i] = tag_out.vld && (tag_out.id == TAG_ID_W'(i));
        for (int unsigned l = 0; l < LANES; l++)
            bus.rsp_out[l*PW +: PW] = (tag_out.vld && tag_out.lane_en[l]) ? prod[l] : '0;
        for (int unsigned s = 0; s < LAT; s++)
            bus.busy = bus.busy | tag_q[s].vld;
    end

endmodule
